// File: rtl/ieee754_div.sv
// Iterative single-precision IEEE754 divider: one quotient bit per clock, denormals flushed to zero.
// Build option IEEE754_DIV_ROUND_EN selects round-to-nearest-even; the default build truncates.
module ieee754_div (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic        busy,
   output logic        done,
   output logic [31:0] dest,
   output logic        flag_dz,
   output logic        flag_inv
);

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_PACK} state_t;

   localparam logic [31:0] QNAN = 32'h7FBF_FFFF;

   state_t             state_q, state_d;
   logic               busy_q, busy_d, done_q, done_d;
   logic               dz_q, dz_d, inv_q, inv_d;
   logic [31:0]        dest_q, dest_d;
   logic [4:0]         cnt_q, cnt_d;
   logic [24:0]        r_q, r_d;
   logic [25:0]        q_q, q_d;
   logic [23:0]        mb_q, mb_d;
   logic               sign_q, sign_d;
   logic signed [9:0]  e0_q, e0_d;
   logic               spec_q, spec_d, spec_dz_q, spec_dz_d, spec_inv_q, spec_inv_d;
   logic [31:0]        spec_res_q, spec_res_d;

   logic [7:0]  ea, eb;
   logic        sign_in, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic        is_spec, new_dz, new_inv;
   logic [31:0] new_res;

   assign ea      = src_a[30:23];
   assign eb      = src_b[30:23];
   assign sign_in = src_a[31] ^ src_b[31];
   // A zero exponent field is zero regardless of mantissa: denormals are flushed.
   assign a_zero  = (ea == 8'h00);
   assign b_zero  = (eb == 8'h00);
   assign a_inf   = (ea == 8'hFF) && (src_a[22:0] == 23'd0);
   assign b_inf   = (eb == 8'hFF) && (src_b[22:0] == 23'd0);
   assign a_nan   = (ea == 8'hFF) && (src_a[22:0] != 23'd0);
   assign b_nan   = (eb == 8'hFF) && (src_b[22:0] != 23'd0);

   // NOTE: every signal gets a default before the if/case chain so no path leaves it unassigned (no latch).
   always_comb begin
      is_spec = 1'b1;
      new_res = QNAN;
      new_dz  = 1'b0;
      new_inv = 1'b0;
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
         new_inv = 1'b1;
      end else if (a_inf) begin
         new_res = {sign_in, 8'hFF, 23'd0};
      end else if (b_inf) begin
         new_res = {sign_in, 31'd0};
      end else if (b_zero) begin
         new_res = {sign_in, 8'hFF, 23'd0};
         new_dz  = 1'b1;
      end else if (a_zero) begin
         new_res = {sign_in, 31'd0};
      end else begin
         is_spec = 1'b0;
      end
   end

   logic [22:0]       mant_t, mant_f;
   logic [23:0]       mant_r;
   logic signed [9:0] e_t, e_r;
   logic              round_inc;
   logic [31:0]       pack_res;
`ifdef IEEE754_DIV_ROUND_EN
   logic              guard, sticky;
`endif

   always_comb begin
      if (q_q[25]) begin
         mant_t = q_q[24:2];
         e_t    = e0_q;
      end else begin
         mant_t = q_q[23:1];
         e_t    = e0_q - 10'sd1;
      end
`ifdef IEEE754_DIV_ROUND_EN
      guard     = q_q[25] ? q_q[1] : q_q[0];
      sticky    = (q_q[25] & q_q[0]) | (|r_q);
      round_inc = guard & (sticky | mant_t[0]);
`else
      round_inc = 1'b0;
`endif
      mant_r = {1'b0, mant_t} + {23'd0, round_inc};
      e_r    = e_t;
      mant_f = mant_r[22:0];
      if (mant_r[23]) begin
         e_r    = e_t + 10'sd1;
         mant_f = 23'd0;
      end
      if (e_r >= 10'sd255)     pack_res = {sign_q, 8'hFF, 23'd0};
      else if (e_r <= 10'sd0)  pack_res = {sign_q, 31'd0};
      else                     pack_res = {sign_q, e_r[7:0], mant_f};
   end

   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      dz_d       = dz_q;
      inv_d      = inv_q;
      dest_d     = dest_q;
      cnt_d      = cnt_q;
      r_d        = r_q;
      q_d        = q_q;
      mb_d       = mb_q;
      sign_d     = sign_q;
      e0_d       = e0_q;
      spec_d     = spec_q;
      spec_dz_d  = spec_dz_q;
      spec_inv_d = spec_inv_q;
      spec_res_d = spec_res_q;
      case (state_q)
         S_IDLE: if (start) begin
            busy_d     = 1'b1;
            dz_d       = 1'b0;
            inv_d      = 1'b0;
            sign_d     = sign_in;
            mb_d       = {1'b1, src_b[22:0]};
            r_d        = {2'b01, src_a[22:0]};
            q_d        = 26'd0;
            cnt_d      = 5'd25;
            e0_d       = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
            spec_d     = is_spec;
            spec_res_d = new_res;
            spec_dz_d  = new_dz;
            spec_inv_d = new_inv;
            state_d    = is_spec ? S_PACK : S_DIV;
         end
         S_DIV: begin
            if (r_q >= {1'b0, mb_q}) begin
               q_d = {q_q[24:0], 1'b1};
               r_d = (r_q - {1'b0, mb_q}) << 1;
            end else begin
               q_d = {q_q[24:0], 1'b0};
               r_d = r_q << 1;
            end
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd0) state_d = S_PACK;
         end
         S_PACK: begin
            dest_d  = spec_q ? spec_res_q : pack_res;
            dz_d    = spec_q & spec_dz_q;
            inv_d   = spec_q & spec_inv_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: non-blocking assignments so every flop samples the pre-edge value of every other flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         dz_q       <= 1'b0;
         inv_q      <= 1'b0;
         dest_q     <= 32'd0;
         cnt_q      <= 5'd0;
         r_q        <= 25'd0;
         q_q        <= 26'd0;
         mb_q       <= 24'd0;
         sign_q     <= 1'b0;
         e0_q       <= 10'sd0;
         spec_q     <= 1'b0;
         spec_dz_q  <= 1'b0;
         spec_inv_q <= 1'b0;
         spec_res_q <= 32'd0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         dz_q       <= dz_d;
         inv_q      <= inv_d;
         dest_q     <= dest_d;
         cnt_q      <= cnt_d;
         r_q        <= r_d;
         q_q        <= q_d;
         mb_q       <= mb_d;
         sign_q     <= sign_d;
         e0_q       <= e0_d;
         spec_q     <= spec_d;
         spec_dz_q  <= spec_dz_d;
         spec_inv_q <= spec_inv_d;
         spec_res_q <= spec_res_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign dest     = dest_q;
   assign flag_dz  = dz_q;
   assign flag_inv = inv_q;

endmodule

// File: tb/tb_ieee754_div.sv
// Self-checking bench for ieee754_div: expected results go into a scoreboard queue at issue
// and are popped when done pulses. Expectations follow IEEE754_DIV_ROUND_EN when it is defined.
module tb_ieee754_div;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] src_a = 32'd0;
   logic [31:0] src_b = 32'd0;
   logic        busy, done, flag_dz, flag_inv;
   logic [31:0] dest;

   ieee754_div dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .src_a    (src_a),
      .src_b    (src_b),
      .busy     (busy),
      .done     (done),
      .dest     (dest),
      .flag_dz  (flag_dz),
      .flag_inv (flag_inv)
   );

   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   typedef struct packed {
      logic [31:0] dest;
      logic        dz;
      logic        inv;
      logic [5:0]  lat;
   } exp_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] d;
      logic        dz;
      logic        inv;
   } vec_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

`ifdef IEEE754_DIV_ROUND_EN
   localparam logic [31:0] ONE_THIRD  = 32'h3EAA_AAAB;
   localparam logic [31:0] TWO_THIRDS = 32'h3F2A_AAAB;
   localparam logic [31:0] NEAR_ONE   = 32'h3F80_0001;
`else
   localparam logic [31:0] ONE_THIRD  = 32'h3EAA_AAAA;
   localparam logic [31:0] TWO_THIRDS = 32'h3F2A_AAAA;
   localparam logic [31:0] NEAR_ONE   = 32'h3F80_0000;
`endif

   // Drive a request and return the edge number on which it was sampled.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, output int acc);
      start = 1'b1;
      src_a = a;
      src_b = b;
      @(posedge clk);
      #1;
      acc   = edge_cnt;
      start = 1'b0;
   endtask

   // Wait (bounded) for done; busy_ok reports busy stayed high until then.
   task automatic wait_done(output logic got, output int de, output logic [31:0] d,
                            output logic dz, output logic inv,
                            output logic busy_ok, output logic busy_end);
      got = 1'b0; de = 0; d = 32'd0; dz = 1'b0; inv = 1'b0; busy_ok = 1'b1; busy_end = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            got = 1'b1; de = edge_cnt; d = dest; dz = flag_dz; inv = flag_inv; busy_end = busy;
            break;
         end
         if (busy !== 1'b1) busy_ok = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b1;
      src_a = 32'h40C0_0000;
      src_b = 32'h4000_0000;
      #12;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL reset_ctrl: busy=%b done=%b, want 0 0", busy, done);
      end
      checks++;
      if (dest !== 32'd0 || flag_dz !== 1'b0 || flag_inv !== 1'b0) begin
         errors++; $display("FAIL reset_data: dest=%h dz=%b inv=%b, want 0 0 0", dest, flag_dz, flag_inv);
      end
      start = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL reset_idle: busy=%b, want 0", busy);
      end
   endtask

   task automatic test_basic();
      int acc, de; logic got, dz, inv, bok, bend; logic [31:0] d; exp_t e;
      sb_q.push_back(exp_t'{32'h4040_0000, 1'b0, 1'b0, 6'd27});
      issue(32'h40C0_0000, 32'h4000_0000, acc);
      wait_done(got, de, d, dz, inv, bok, bend);
      e = sb_q.pop_front();
      checks++;
      if (!got) begin
         errors++; $display("FAIL basic_done: no done within 40 cycles");
      end else begin
         checks++;
         if (d !== e.dest) begin errors++; $display("FAIL basic_dest: got %h want %h", d, e.dest); end
         checks++;
         if ({dz, inv} !== {e.dz, e.inv}) begin errors++; $display("FAIL basic_flags: got %b%b want %b%b", dz, inv, e.dz, e.inv); end
         checks++;
         if (de - acc !== int'(e.lat)) begin errors++; $display("FAIL basic_latency: got %0d want %0d", de - acc, e.lat); end
         checks++;
         if (!bok || bend !== 1'b0) begin errors++; $display("FAIL basic_busy: held=%b at_done=%b want 1 0", bok, bend); end
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || dest !== e.dest) begin
            errors++; $display("FAIL basic_hold: done=%b dest=%h want 0 %h", done, dest, e.dest);
         end
      end
   endtask

   // Runs a vector table; lat is the expected accept-to-done edge count.
   task automatic run_table(input string tag, input vec_t vecs[$], input int lat);
      int acc, de; logic got, dz, inv, bok, bend; logic [31:0] d; exp_t e;
      foreach (vecs[i]) begin
         sb_q.push_back(exp_t'{vecs[i].d, vecs[i].dz, vecs[i].inv, 6'(lat)});
         issue(vecs[i].a, vecs[i].b, acc);
         wait_done(got, de, d, dz, inv, bok, bend);
         e = sb_q.pop_front();
         checks++;
         if (!got) begin
            errors++; $display("FAIL %s[%0d] %h/%h: no done within 40 cycles", tag, i, vecs[i].a, vecs[i].b);
         end else begin
            checks++;
            if (d !== e.dest || {dz, inv} !== {e.dz, e.inv}) begin
               errors++;
               $display("FAIL %s[%0d] %h/%h: got %h dz=%b inv=%b want %h dz=%b inv=%b",
                        tag, i, vecs[i].a, vecs[i].b, d, dz, inv, e.dest, e.dz, e.inv);
            end
            checks++;
            if (de - acc !== int'(e.lat) || !bok || bend !== 1'b0) begin
               errors++;
               $display("FAIL %s[%0d] timing: latency %0d busy_held=%b busy_at_done=%b want %0d 1 0",
                        tag, i, de - acc, bok, bend, e.lat);
            end
         end
      end
   endtask

   task automatic test_special();
      vec_t vecs[$];
      vecs.push_back(vec_t'{32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1'b1, 1'b0});
      vecs.push_back(vec_t'{32'h0000_0000, 32'h0000_0000, 32'h7FBF_FFFF, 1'b0, 1'b1});
      vecs.push_back(vec_t'{32'h7FC0_0000, 32'h3F80_0000, 32'h7FBF_FFFF, 1'b0, 1'b1});
      vecs.push_back(vec_t'{32'h3F80_0000, 32'h7F80_0001, 32'h7FBF_FFFF, 1'b0, 1'b1});
      vecs.push_back(vec_t'{32'h7F80_0000, 32'hFF80_0000, 32'h7FBF_FFFF, 1'b0, 1'b1});
      vecs.push_back(vec_t'{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b0, 1'b0});
      vecs.push_back(vec_t'{32'h7F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b0, 1'b0});
      vecs.push_back(vec_t'{32'h4000_0000, 32'hFF80_0000, 32'h8000_0000, 1'b0, 1'b0});
      vecs.push_back(vec_t'{32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b0, 1'b0});
      vecs.push_back(vec_t'{32'h0040_0000, 32'h3F80_0000, 32'h0000_0000, 1'b0, 1'b0});
      vecs.push_back(vec_t'{32'h3F80_0000, 32'h8040_0000, 32'hFF80_0000, 1'b1, 1'b0});
      run_table("special", vecs, 1);
   endtask

   task automatic test_normal();
      vec_t vecs[$];
      vecs.push_back(vec_t'{32'h3F80_0000, 32'h4040_0000, ONE_THIRD,    1'b0, 1'b0});
      vecs.push_back(vec_t'{32'h4000_0000, 32'h4040_0000, TWO_THIRDS,   1'b0, 1'b0});
      vecs.push_back(vec_t'{32'h3F80_0000, 32'h3F7F_FFFF, NEAR_ONE,     1'b0, 1'b0});
      vecs.push_back(vec_t'{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0});
      vecs.push_back(vec_t'{32'h4120_0000, 32'h40A0_0000, 32'h4000_0000, 1'b0, 1'b0});
      vecs.push_back(vec_t'{32'h40E0_0000, 32'h4000_0000, 32'h4060_0000, 1'b0, 1'b0});
      vecs.push_back(vec_t'{32'hC100_0000, 32'h3F00_0000, 32'hC180_0000, 1'b0, 1'b0});
      vecs.push_back(vec_t'{32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 1'b0, 1'b0});
      vecs.push_back(vec_t'{32'hFF00_0000, 32'h3E80_0000, 32'hFF80_0000, 1'b0, 1'b0});
      vecs.push_back(vec_t'{32'h7F7F_FFFF, 32'h3F80_0000, 32'h7F7F_FFFF, 1'b0, 1'b0});
      vecs.push_back(vec_t'{32'h0080_0000, 32'h3F80_0000, 32'h0080_0000, 1'b0, 1'b0});
      vecs.push_back(vec_t'{32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0});
      vecs.push_back(vec_t'{32'h0080_0000, 32'h4B00_0000, 32'h0000_0000, 1'b0, 1'b0});
      vecs.push_back(vec_t'{32'h8080_0000, 32'h4000_0000, 32'h8000_0000, 1'b0, 1'b0});
      run_table("normal", vecs, 27);
   endtask

   task automatic test_ignore_start();
      int acc, de, extra; logic got, dz, inv, bok, bend; logic [31:0] d; exp_t e;
      sb_q.push_back(exp_t'{32'h4040_0000, 1'b0, 1'b0, 6'd27});
      issue(32'h40C0_0000, 32'h4000_0000, acc);
      repeat (9) @(posedge clk);
      #1;
      start = 1'b1; src_a = 32'h3F80_0000; src_b = 32'h4040_0000;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(got, de, d, dz, inv, bok, bend);
      e = sb_q.pop_front();
      checks++;
      if (!got || d !== e.dest || de - acc !== int'(e.lat)) begin
         errors++; $display("FAIL ignore_start: got=%b dest=%h latency=%0d want 1 %h %0d", got, d, de - acc, e.dest, e.lat);
      end
      extra = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) extra++;
      end
      checks++;
      if (extra != 0) begin
         errors++; $display("FAIL ignore_not_queued: %0d busy/done cycles after result, want 0", extra);
      end
   endtask

   task automatic test_back_to_back();
      int acc1, acc2, de1, de2; logic got1, got2, dz, inv, bok, bend; logic [31:0] d1, d2; exp_t e;
      sb_q.push_back(exp_t'{32'h4040_0000, 1'b0, 1'b0, 6'd27});
      issue(32'h40C0_0000, 32'h4000_0000, acc1);
      wait_done(got1, de1, d1, dz, inv, bok, bend);
      sb_q.push_back(exp_t'{ONE_THIRD, 1'b0, 1'b0, 6'd27});
      issue(32'h3F80_0000, 32'h4040_0000, acc2);
      wait_done(got2, de2, d2, dz, inv, bok, bend);
      e = sb_q.pop_front();
      checks++;
      if (!got1 || d1 !== e.dest) begin
         errors++; $display("FAIL b2b_first: got=%b dest=%h want 1 %h", got1, d1, e.dest);
      end
      e = sb_q.pop_front();
      checks++;
      if (!got2 || d2 !== e.dest) begin
         errors++; $display("FAIL b2b_second: got=%b dest=%h want 1 %h", got2, d2, e.dest);
      end
      checks++;
      if (de2 - de1 !== 28) begin
         errors++; $display("FAIL b2b_spacing: %0d edges between done pulses, want 28", de2 - de1);
      end
   endtask

   task automatic test_reset_abort();
      int acc, seen;
      issue(32'h40C0_0000, 32'h4000_0000, acc);
      repeat (15) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || dest !== 32'd0) begin
         errors++; $display("FAIL abort_reset: busy=%b done=%b dest=%h want 0 0 0", busy, done, dest);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      checks++;
      if (seen != 0 || dest !== 32'd0) begin
         errors++; $display("FAIL abort_no_done: %0d busy/done cycles, dest=%h want 0 0", seen, dest);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_special();
      test_normal();
      test_ignore_start();
      test_back_to_back();
      test_reset_abort();
      checks++;
      if (sb_q.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
